// File: rtl/adc_serial_responder.sv
// ADC-side loopback partner for the converter control FSM: receives 32-bit serial
// config frames into a register file and answers calibration requests with CalRunning.

module adc_sync_bit #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic Clock,
  input  logic Reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

module adc_serial_responder #(
  parameter int          CAL_MIN_HIGH   = 8,
  parameter int          CAL_RUN_CYCLES = 10,
  parameter logic [11:0] HEADER         = 12'h001
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        InSclk,
  input  logic        InSdata,
  input  logic        InSelect,
  input  logic        InPD,
  input  logic        InPDQ,
  input  logic        InCal,
  output logic        OutCalRunning,
  input  logic [3:0]  RegAddr,
  output logic [15:0] RegData,
  output logic        FrameValid,
  output logic [3:0]  FrameAddr,
  output logic [15:0] FrameData,
  output logic        FrameError
);

  // Synchronizer lanes; Select idles high, everything else low.
  localparam int NSYNC = 6;
  localparam int S_SCLK = 0, S_SDATA = 1, S_SEL = 2, S_CAL = 3, S_PD = 4, S_PDQ = 5;
  localparam logic [NSYNC-1:0] SYNC_RST = 6'b000100;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RUN  = 2'd3;

  localparam int CW = 16;

  logic [NSYNC-1:0] pins, synced;
  assign pins = {InPDQ, InPD, InCal, InSelect, InSdata, InSclk};

  for (genvar i = 0; i < NSYNC; i++) begin : gSync
    adc_sync_bit #(.RST_VAL(SYNC_RST[i])) uSync (
      .Clock (Clock),
      .Reset (Reset),
      .d     (pins[i]),
      .q     (synced[i])
    );
  end

  logic sclkPrev, selPrev, calPrev;
  logic sclkRise, selFall, selRise, calRise, calFall;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sclkPrev <= 1'b0;
      selPrev  <= 1'b1;
      calPrev  <= 1'b0;
    end else begin
      sclkPrev <= synced[S_SCLK];
      selPrev  <= synced[S_SEL];
      calPrev  <= synced[S_CAL];
    end
  end

  assign sclkRise = synced[S_SCLK] & ~sclkPrev;
  assign selFall  = ~synced[S_SEL] & selPrev;
  assign selRise  = synced[S_SEL] & ~selPrev;
  assign calRise  = synced[S_CAL] & ~calPrev;
  assign calFall  = ~synced[S_CAL] & calPrev;

  // Frame receiver
  logic [31:0]        shiftReg;
  logic [5:0]         bitCnt;
  logic [14:0][15:0]  regFile;
  logic               frameOk;

  assign frameOk = (bitCnt == 6'd32) && (shiftReg[31:20] == HEADER);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      shiftReg   <= '0;
      bitCnt     <= '0;
      regFile    <= '0;
      FrameValid <= 1'b0;
      FrameError <= 1'b0;
      FrameAddr  <= '0;
      FrameData  <= '0;
    end else begin
      FrameValid <= 1'b0;
      FrameError <= 1'b0;
      if (selFall) begin
        shiftReg <= '0;
        bitCnt   <= '0;
      end else if (sclkRise && !synced[S_SEL]) begin
        // Bits past 32 only push the counter to 33 so the frame is rejected.
        if (bitCnt < 6'd32) begin
          shiftReg <= {shiftReg[30:0], synced[S_SDATA]};
          bitCnt   <= bitCnt + 6'd1;
        end else begin
          bitCnt <= 6'd33;
        end
      end else if (selRise) begin
        if (frameOk) begin
          FrameValid <= 1'b1;
          FrameAddr  <= shiftReg[19:16];
          FrameData  <= shiftReg[15:0];
          if (shiftReg[19:16] != 4'hF)
            regFile[shiftReg[19:16]] <= shiftReg[15:0];
        end else if (bitCnt != 6'd0) begin
          FrameError <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    RegData = '0;
    if (RegAddr == 4'hF)
      RegData = {15'b0, synced[S_PDQ]};
    else
      RegData = regFile[RegAddr];
  end

  // Calibration FSM
  logic [1:0]    calState;
  logic [CW-1:0] calCnt;
  logic          pd;

  assign pd = synced[S_PD];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      calState      <= ST_IDLE;
      calCnt        <= '0;
      OutCalRunning <= 1'b0;
    end else begin
      case (calState)
        ST_IDLE: begin
          if (calRise && !pd) begin
            calState <= ST_ARM;
            calCnt   <= '0;
          end
        end
        ST_ARM: begin
          if (pd || calFall)
            calState <= ST_IDLE;
          else if (calCnt == CW'(CAL_MIN_HIGH - 1))
            calState <= ST_WAIT;
          else
            calCnt <= calCnt + 1'b1;
        end
        ST_WAIT: begin
          if (pd) begin
            calState <= ST_IDLE;
          end else if (calFall) begin
            calState      <= ST_RUN;
            calCnt        <= CW'(CAL_RUN_CYCLES - 1);
            OutCalRunning <= 1'b1;
          end
        end
        ST_RUN: begin
          if (pd || calCnt == '0) begin
            calState      <= ST_IDLE;
            OutCalRunning <= 1'b0;
          end else begin
            calCnt <= calCnt - 1'b1;
          end
        end
        default: begin
          calState      <= ST_IDLE;
          OutCalRunning <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/adc_serial_responder.md
Name: adc_serial_responder

Overview:
Synthesizable ADC-side model of the converter's serial configuration and calibration interface. It receives the 32-bit frames driven on OutSclk/OutSdata/OutSelect by the ADC control FSM and writes them into a register file. It also answers OutCal with a CalRunning pulse. It sits on the board-model side of the ADC control FSM and serves as its loopback partner in simulation and on-FPGA self-test.

Parameters:
CAL_MIN_HIGH, 8, minimum number of Clock cycles InCal must be high for a calibration request to count
CAL_RUN_CYCLES, 10, number of Clock cycles OutCalRunning stays high
HEADER, 12'h001, required frame header in bits [31:20]

Ports:
Clock  input  1  system clock; all logic on its rising edge
Reset  input  1  asynchronous, active-high reset
InSclk  input  1  serial clock from the control FSM; asynchronous to Clock
InSdata  input  1  serial data, MSB first, sampled on InSclk rising edge
InSelect  input  1  frame select, active low
InPD  input  1  I-channel power-down; aborts and blocks calibration
InPDQ  input  1  Q-channel power-down; stored only, readable at RegAddr 4'hF bit 0
InCal  input  1  calibration request
OutCalRunning  output  1  calibration in progress
RegAddr  input  4  register read address
RegData  output  16  combinational read of reg[RegAddr]; address 4'hF returns {15'b0, synced InPDQ}
FrameValid  output  1  one-cycle pulse when a frame is accepted
FrameAddr  output  4  address of the last accepted frame
FrameData  output  16  data of the last accepted frame
FrameError  output  1  one-cycle pulse when a frame is rejected

Behaviour:
- Reset (asynchronous, active-high) clears: all 15 registers (addresses 0..14) to 16'h0000, FrameAddr/FrameData to 0, FrameValid/FrameError/OutCalRunning to 0, bit counter to 0, cal FSM to IDLE. Synchronizer flops reset to idle levels: Sclk 0, Select 1, Cal 0, PD 0.
- InSclk, InSdata, InSelect, InCal, InPD and InPDQ each pass through a 2-flop synchronizer. Edges are detected by comparing the synced value with a registered previous value. The "sampling edge" is the first Clock edge that sees the new pin level. Detection resolves at the 2nd edge; registered outputs change at the 3rd edge.
- Frame receive:
  - Select falling: clear the 32-bit shift register and the 6-bit bit counter.
  - Each Sclk rising edge while Select is low: shift in Sdata (MSB first) and increment the counter. The counter saturates at 33, so extra bits are tracked as overflow and the shift register stops at 32 bits.
  - Select rising, counter == 32 and bits[31:20] == HEADER: write reg[bits[19:16]] = bits[15:0], latch FrameAddr/FrameData, pulse FrameValid for 1 cycle.
  - A write to address 4'hF is accepted and pulses FrameValid, but no register is written.
  - Select rising with counter between 1 and 31, counter == 33, or a header mismatch: pulse FrameError for 1 cycle. Registers and Frame* outputs are unchanged.
  - Select rising with counter == 0: no pulse.
  - Sclk edges while Select is high are ignored.
  - Select rising and falling in the same synced cycle cannot occur because Select is synchronized; the minimum high time is 2 Clock cycles.
- Calibration FSM (states IDLE, ARM, WAIT_LOW, RUN):
  - IDLE: on Cal rising with PD low, go to ARM and clear the counter. Cal edges while PD is high are ignored.
  - ARM: count cycles while Cal is high. At count == CAL_MIN_HIGH-1, go to WAIT_LOW. If Cal falls earlier, return to IDLE silently (a short pulse is ignored).
  - WAIT_LOW: on Cal falling, go to RUN, load the counter with CAL_RUN_CYCLES-1, and set OutCalRunning = 1.
  - RUN: decrement each cycle. At 0, clear OutCalRunning and return to IDLE. OutCalRunning is therefore high for exactly CAL_RUN_CYCLES cycles.
  - Cal edges during RUN are ignored; no re-trigger.
  - PD high in ARM, WAIT_LOW or RUN: go to IDLE and clear OutCalRunning on the next edge.
  - Latency: OutCalRunning rises at the 3rd Clock edge counting the edge that samples Cal low.
- Reset mid-frame or mid-calibration: everything is forced to reset values immediately. A partially received frame is discarded with no FrameError.

Test Plan:
- Frame 32'h0013_A5C3 (Sclk period 8 Clock cycles) -> FrameValid 1 cycle, FrameAddr = 4'h3, FrameData = 16'hA5C3, RegAddr = 3 reads 16'hA5C3, other registers 0.
- Frame with header 12'h002, then a 20-bit frame, then a 33-bit frame -> three FrameError pulses, no FrameValid, all registers unchanged.
- InCal high 20 cycles then low, CAL_RUN_CYCLES = 10 -> OutCalRunning high exactly 10 cycles, rising on the 3rd edge after Cal is sampled low.
- InCal high 5 cycles (< CAL_MIN_HIGH) -> OutCalRunning stays 0. A second InCal pulse of 20 cycles then triggers normally.
- InPD asserted 4 cycles into RUN -> OutCalRunning drops within 3 edges and the FSM is in IDLE. An InCal pulse while InPD is high is ignored.
- Reset asserted at bit 17 of a frame and again during RUN -> all outputs 0 immediately, no FrameError. The next full frame is accepted normally.
